// File: rtl/lc3_controller.sv
// LC3 pipeline controller: stage enables, bypass selects, memory sequencing and branch flush.
// Optional stall-cycle counter is compiled in when LC3_CTRL_PERF_CNT_EN is defined.
module lc3_controller #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        complete_data,
  input  logic        complete_instr,
  input  logic [15:0] IR,
  input  logic [15:0] IR_Exec,
  input  logic [2:0]  NZP,
  input  logic [2:0]  psr,
  output logic        enable_fetch,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        enable_updatePC,
  output logic        br_taken,
  output logic        squash_decode,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2,
  output logic        bypass_mem_1,
  output logic        bypass_mem_2,
  output logic [1:0]  mem_state,
  output logic [15:0] stall_cycles
);

  typedef enum logic [2:0] {
    S_RUN,
    S_MEM_IND,
    S_MEM_DATA,
    S_BR_RES,
    S_FLUSH
  } state_t;

  state_t     state;
  logic [2:0] flush_cnt;
  logic       ll_valid;
  logic [2:0] ll_dr;

  logic [3:0] ir_op, ex_op;
  logic       ir_load, ir_store, ir_ctrl, ir_ind;
  logic       ex_alu, ex_load, ex_store;
  logic       src1_used, src2_used;
  logic [2:0] src1, src2;
  logic       unused_bits;

  assign ir_op    = IR[15:12];
  assign ex_op    = IR_Exec[15:12];
  assign ir_load  = (ir_op == 4'b0010) || (ir_op == 4'b0110) || (ir_op == 4'b1010);
  assign ir_store = (ir_op == 4'b0011) || (ir_op == 4'b0111) || (ir_op == 4'b1011);
  assign ir_ctrl  = (ir_op == 4'b0000) || (ir_op == 4'b1100);
  assign ir_ind   = (ir_op == 4'b1010) || (ir_op == 4'b1011);
  assign ex_alu   = (ex_op == 4'b0001) || (ex_op == 4'b0101) || (ex_op == 4'b1001);
  assign ex_load  = (ex_op == 4'b0010) || (ex_op == 4'b0110) || (ex_op == 4'b1010);
  assign ex_store = (ex_op == 4'b0011) || (ex_op == 4'b0111) || (ex_op == 4'b1011);

  assign src1      = IR[8:6];
  assign src2      = ir_store ? IR[11:9] : IR[2:0];
  assign src1_used = (ir_op == 4'b0001) || (ir_op == 4'b0101) || (ir_op == 4'b1001) ||
                     (ir_op == 4'b0110) || (ir_op == 4'b0111) || (ir_op == 4'b1100);
  assign src2_used = (((ir_op == 4'b0001) || (ir_op == 4'b0101)) && !IR[5]) || ir_store;
  assign unused_bits = ^{IR[4:3], IR_Exec[8:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_RUN;
      flush_cnt <= '0;
      ll_valid  <= 1'b0;
      ll_dr     <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (complete_instr) begin
            ll_valid <= 1'b0;
            if (ir_ind)                    state <= S_MEM_IND;
            else if (ir_load || ir_store)  state <= S_MEM_DATA;
            else if (ir_ctrl)              state <= S_BR_RES;
          end
        end
        S_MEM_IND: begin
          if (complete_data) state <= S_MEM_DATA;
        end
        S_MEM_DATA: begin
          if (complete_data) begin
            state <= S_RUN;
            if (ex_load) begin
              ll_dr    <= IR_Exec[11:9];
              ll_valid <= 1'b1;
            end
          end
        end
        S_BR_RES: begin
          state     <= S_FLUSH;
          flush_cnt <= 3'(FLUSH_CYCLES);
        end
        S_FLUSH: begin
          flush_cnt <= flush_cnt - 3'd1;
          if (flush_cnt == 3'd1) state <= S_RUN;
        end
        default: state <= S_RUN;
      endcase
    end
  end

  // Outputs are held idle while reset is asserted, independent of state.
  always_comb begin
    enable_fetch     = 1'b0;
    enable_decode    = 1'b0;
    enable_execute   = 1'b0;
    enable_writeback = 1'b0;
    enable_updatePC  = 1'b0;
    br_taken         = 1'b0;
    squash_decode    = 1'b0;
    bypass_alu_1     = 1'b0;
    bypass_alu_2     = 1'b0;
    bypass_mem_1     = 1'b0;
    bypass_mem_2     = 1'b0;
    mem_state        = 2'd3;
    if (rst) begin
      case (state)
        S_RUN: begin
          {enable_fetch, enable_decode, enable_execute, enable_updatePC} = {4{complete_instr}};
          enable_writeback = 1'b1;
        end
        S_MEM_IND: mem_state = 2'd1;
        S_MEM_DATA: begin
          if (ex_load)       mem_state = 2'd0;
          else if (ex_store) mem_state = 2'd2;
          enable_writeback = complete_data && ex_load;
        end
        S_BR_RES: begin
          enable_updatePC  = 1'b1;
          enable_writeback = 1'b1;
          br_taken = (ex_op == 4'b1100) || ((ex_op == 4'b0000) && |(NZP & psr));
        end
        S_FLUSH: begin
          {enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC} = '1;
          squash_decode = 1'b1;
        end
        default: ;
      endcase
      bypass_alu_1 = ex_alu && (IR_Exec[11:9] == src1) && src1_used;
      bypass_alu_2 = ex_alu && (IR_Exec[11:9] == src2) && src2_used;
      bypass_mem_1 = ll_valid && (ll_dr == src1) && src1_used && !bypass_alu_1;
      bypass_mem_2 = ll_valid && (ll_dr == src2) && src2_used && !bypass_alu_2;
    end
  end

`ifdef LC3_CTRL_PERF_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if ((state != S_RUN) && (stall_q != '1)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_lc3_controller.sv
// Bench for lc3_controller: directed scenarios plus randomized traffic against a
// pending-work model (memory phases left, branch pending, flush cycles left).
module tb_lc3_controller;
  localparam int unsigned FC = 2;
`ifdef LC3_CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, complete_data, complete_instr;
  logic [15:0] IR, IR_Exec;
  logic [2:0]  NZP, psr;
  logic        enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC;
  logic        br_taken, squash_decode;
  logic        bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
  logic [1:0]  mem_state;
  logic [15:0] stall_cycles;

  lc3_controller #(.FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .complete_data(complete_data), .complete_instr(complete_instr),
    .IR(IR), .IR_Exec(IR_Exec), .NZP(NZP), .psr(psr),
    .enable_fetch(enable_fetch), .enable_decode(enable_decode), .enable_execute(enable_execute),
    .enable_writeback(enable_writeback), .enable_updatePC(enable_updatePC),
    .br_taken(br_taken), .squash_decode(squash_decode),
    .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2),
    .bypass_mem_1(bypass_mem_1), .bypass_mem_2(bypass_mem_2),
    .mem_state(mem_state), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int          m_mem_left;
  bit          m_br;
  int          m_flush_left;
  bit          m_ll_valid;
  logic [2:0]  m_ll_dr;
  int unsigned m_stall;
  logic        last_exec;

  function automatic logic [3:0] opc(input logic [15:0] i);
    return i[15:12];
  endfunction
  function automatic logic is_alu(input logic [15:0] i);
    return opc(i) inside {4'h1, 4'h5, 4'h9};
  endfunction
  function automatic logic is_load(input logic [15:0] i);
    return opc(i) inside {4'h2, 4'h6, 4'hA};
  endfunction
  function automatic logic is_store(input logic [15:0] i);
    return opc(i) inside {4'h3, 4'h7, 4'hB};
  endfunction
  function automatic logic uses1(input logic [15:0] i);
    return is_alu(i) || (opc(i) inside {4'h6, 4'h7, 4'hC});
  endfunction
  function automatic logic uses2(input logic [15:0] i);
    return ((opc(i) inside {4'h1, 4'h5}) && !i[5]) || is_store(i);
  endfunction
  function automatic logic [2:0] sel2(input logic [15:0] i);
    return is_store(i) ? i[11:9] : i[2:0];
  endfunction
  function automatic bit m_in_run();
    return (m_mem_left == 0) && !m_br && (m_flush_left == 0);
  endfunction

  task automatic model_reset();
    m_mem_left = 0; m_br = 0; m_flush_left = 0;
    m_ll_valid = 0; m_ll_dr = '0; m_stall = 0;
  endtask

  task automatic model_expect(output logic [28:0] v, output logic ex);
    logic f, d, e, w, u, b, s, a1, a2, b1, b2;
    logic [1:0]  ms;
    logic [15:0] st;
    {f, d, e, w, u, b, s, a1, a2, b1, b2} = '0;
    ms = 2'd3;
    st = PERF ? 16'(m_stall) : 16'h0;
    if (rst) begin
      if (m_flush_left > 0) begin
        {f, d, e, w, u, s} = '1;
      end else if (m_br) begin
        u = 1; w = 1;
        b = (opc(IR_Exec) == 4'hC) || ((opc(IR_Exec) == 4'h0) && ((NZP & psr) != 3'b000));
      end else if (m_mem_left == 2) begin
        ms = 2'd1;
      end else if (m_mem_left == 1) begin
        ms = is_load(IR_Exec) ? 2'd0 : (is_store(IR_Exec) ? 2'd2 : 2'd3);
        w  = complete_data && is_load(IR_Exec);
      end else begin
        {f, d, e, u} = {4{complete_instr}};
        w = 1;
      end
      a1 = is_alu(IR_Exec) && (IR_Exec[11:9] == IR[8:6]) && uses1(IR);
      a2 = is_alu(IR_Exec) && (IR_Exec[11:9] == sel2(IR)) && uses2(IR);
      b1 = m_ll_valid && (m_ll_dr == IR[8:6]) && uses1(IR) && !a1;
      b2 = m_ll_valid && (m_ll_dr == sel2(IR)) && uses2(IR) && !a2;
    end
    v  = {f, d, e, w, u, b, s, a1, a2, b1, b2, ms, st};
    ex = e;
  endtask

  task automatic model_advance();
    if (!rst) begin
      model_reset();
      return;
    end
    if (!m_in_run() && m_stall < 32'hFFFF) m_stall++;
    if (m_flush_left > 0) begin
      m_flush_left--;
    end else if (m_br) begin
      m_br = 0;
      m_flush_left = FC;
    end else if (m_mem_left == 2) begin
      if (complete_data) m_mem_left = 1;
    end else if (m_mem_left == 1) begin
      if (complete_data) begin
        m_mem_left = 0;
        if (is_load(IR_Exec)) begin
          m_ll_valid = 1;
          m_ll_dr    = IR_Exec[11:9];
        end
      end
    end else if (complete_instr) begin
      m_ll_valid = 0;
      if (opc(IR) inside {4'hA, 4'hB})        m_mem_left = 2;
      else if (is_load(IR) || is_store(IR))   m_mem_left = 1;
      else if (opc(IR) inside {4'h0, 4'hC})   m_br = 1;
    end
  endtask

  // Single compare point: settle inputs, then check every output against the model.
  task automatic cyc();
    logic [28:0] exp_v, act_v;
    #1;
    model_expect(exp_v, last_exec);
    act_v = {enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC,
             br_taken, squash_decode, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2,
             mem_state, stall_cycles};
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL model_cmp t=%0t got=%h exp=%h", $time, act_v, exp_v);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    model_advance();
    if (rst && last_exec) IR_Exec = IR;
  endtask

  task automatic lit(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ci, input logic cd, input logic [15:0] ir);
    complete_instr = ci; complete_data = cd; IR = ir;
  endtask

  logic [31:0] r;
  logic [3:0]  ops [12] = '{4'h1, 4'h5, 4'h9, 4'h2, 4'h6, 4'hA, 4'h3, 4'h7, 4'hB, 4'h0, 4'hC, 4'h4};

  initial begin
    rst = 0; NZP = 3'b000; psr = 3'b000;
    drive(1'b1, 1'b0, 16'h5020);
    IR_Exec = 16'h5020;
    last_exec = 0;
    model_reset();
    cyc();
    lit("reset_enables", 16'({enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC}), 16'h0);
    lit("reset_mem_state", 16'(mem_state), 16'd3);
    lit("reset_stall", stall_cycles, 16'h0);
    adv(); adv();
    rst = 1;

    // ALU forwarding, register and immediate forms
    drive(1'b0, 1'b0, 16'h1200); IR_Exec = 16'h1042;
    cyc();
    lit("byp_alu_both", 16'({bypass_alu_1, bypass_alu_2}), 16'b11);
    adv();
    IR = 16'h1220; IR_Exec = 16'h1042;
    cyc();
    lit("byp_alu_imm", 16'({bypass_alu_1, bypass_alu_2}), 16'b10);
    adv();

    // LDI: two memory phases, two cycles each
    drive(1'b1, 1'b0, 16'hA401); cyc(); lit("ldi_ms0", 16'(mem_state), 16'd3); adv();
    drive(1'b1, 1'b0, 16'hA401); cyc(); lit("ldi_ms1", 16'(mem_state), 16'd1);
    lit("ldi_en1", 16'({enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC}), 16'h0); adv();
    drive(1'b1, 1'b1, 16'hA401); cyc(); lit("ldi_ms2", 16'(mem_state), 16'd1); adv();
    drive(1'b1, 1'b0, 16'hA401); cyc(); lit("ldi_ms3", 16'(mem_state), 16'd0);
    lit("ldi_wb3", 16'(enable_writeback), 16'd0); adv();
    drive(1'b1, 1'b1, 16'hA401); cyc(); lit("ldi_ms4", 16'(mem_state), 16'd0);
    lit("ldi_wb4", 16'({enable_fetch, enable_writeback}), 16'b01); adv();
    drive(1'b0, 1'b0, 16'h5020); cyc(); lit("ldi_ms5", 16'(mem_state), 16'd3); adv();

    // ST with immediate completion
    drive(1'b1, 1'b0, 16'h3601); cyc(); adv();
    drive(1'b0, 1'b1, 16'h3601); cyc(); lit("st_ms", 16'(mem_state), 16'd2);
    lit("st_wb", 16'(enable_writeback), 16'd0); adv();
    drive(1'b0, 1'b0, 16'h5020); cyc(); lit("st_done", 16'(mem_state), 16'd3); adv();

    // Branches: BRz taken, BRz not taken, JMP
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, (k == 2) ? 16'hC1C0 : 16'h0405);
      NZP = 3'b010; psr = (k == 0) ? 3'b010 : ((k == 1) ? 3'b100 : 3'b000);
      cyc(); adv();
      drive(1'b0, 1'b0, 16'h5020); cyc();
      lit("br_taken", 16'(br_taken), (k == 1) ? 16'd0 : 16'd1);
      lit("br_upd", 16'({enable_fetch, enable_updatePC}), 16'b01); adv();
      for (int j = 0; j < int'(FC); j++) begin
        cyc(); lit("flush_sq", 16'({squash_decode, enable_fetch}), 16'b11); adv();
      end
      cyc(); lit("flush_end", 16'(squash_decode), 16'd0); adv();
    end

    // LDR R4 then ADD R0,R4,R4 uses the memory bypass once
    drive(1'b1, 1'b0, 16'h6840); cyc(); adv();
    drive(1'b0, 1'b1, 16'h6840); cyc(); lit("ldr_wb", 16'(enable_writeback), 16'd1); adv();
    drive(1'b1, 1'b0, 16'h1104); cyc();
    lit("mem_byp", 16'({bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2}), 16'b0011); adv();
    drive(1'b0, 1'b0, 16'h1104); IR_Exec = 16'h6840; cyc();
    lit("mem_byp_clr", 16'({bypass_mem_1, bypass_mem_2}), 16'b00); adv();

    // Async reset while in MEM_IND
    drive(1'b1, 1'b0, 16'hA401); cyc(); adv();
    drive(1'b0, 1'b0, 16'hA401); cyc();
    #2; rst = 0; model_reset();
    cyc(); lit("rst_mid_ms", 16'(mem_state), 16'd3);
    lit("rst_mid_en", 16'({enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC}), 16'h0);
    adv(); cyc(); adv();
    rst = 1; drive(1'b1, 1'b0, 16'h1200); cyc();
    lit("rst_release", 16'({enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC}), 16'h1F);
    adv();

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 399) != 0);
      if (!rst) model_reset();
      r = $urandom;
      IR = {ops[$urandom_range(0, 11)], r[11:0]};
      complete_instr = ($urandom_range(0, 9) < 7);
      complete_data  = ($urandom_range(0, 9) < 4);
      NZP = 3'($urandom_range(0, 7));
      psr = 3'($urandom_range(0, 7));
      cyc();
      adv();
    end
    rst = 1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
